// File: rtl/pause_flow_scheduler_if.sv
// PAUSE request handshake between the flow scheduler and the MAC transmit side.
interface pause_flow_scheduler_if;
  logic        tx_pause_req;
  logic [15:0] tx_pause_val;
  logic [47:0] tx_pause_source_addr;
  logic        tx_pause_ack;

  modport master (output tx_pause_req, tx_pause_val, tx_pause_source_addr, input tx_pause_ack);
  modport slave  (input tx_pause_req, tx_pause_val, tx_pause_source_addr, output tx_pause_ack);
endinterface

// File: rtl/pause_flow_scheduler.sv
// Issues XOFF/XON PAUSE requests from RX FIFO fill level with watermark hysteresis
// and periodic XOFF refresh while the FIFO stays congested.
module pause_flow_scheduler #(
  parameter int          LVL_W          = 5,
  parameter int          HIGH_WM        = 24,
  parameter int          LOW_WM         = 8,
  parameter logic [15:0] PAUSE_QUANTA   = 16'hFFFF,
  parameter int          QUANTA_CYCLES  = 64,
  parameter int          REFRESH_MARGIN = 256,
  parameter logic [47:0] SRC_ADDR       = 48'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [LVL_W-1:0]      fifo_level,
  pause_flow_scheduler_if.master mac,
  output logic                  xoff_active,
  output logic [15:0]           xoff_count
);

  // Refresh fires REFRESH_MARGIN cycles before the peer's pause would expire.
  localparam int          R_RAW  = int'(PAUSE_QUANTA) * QUANTA_CYCLES - REFRESH_MARGIN;
  localparam logic [31:0] R_LOAD = (R_RAW <= 0) ? 32'd1 : 32'(R_RAW);

  localparam logic [LVL_W-1:0] HIGH_LVL = LVL_W'(HIGH_WM);
  localparam logic [LVL_W-1:0] LOW_LVL  = LVL_W'(LOW_WM);

  typedef enum logic [1:0] {IDLE, SEND_XOFF, PAUSED, SEND_XON} state_t;

  state_t      state, state_nxt;
  logic [31:0] timer;
  logic        req_r;
  logic [15:0] val_r;
  logic        ack_take;

  // An ack with no request outstanding is meaningless and dropped.
  assign ack_take = mac.tx_pause_ack && req_r;

  assign mac.tx_pause_req         = req_r;
  assign mac.tx_pause_val         = val_r;
  assign mac.tx_pause_source_addr = SRC_ADDR;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable && fifo_level >= HIGH_LVL) state_nxt = SEND_XOFF;
      SEND_XOFF: if (ack_take) state_nxt = PAUSED;
      PAUSED: begin
        if (!enable || fifo_level <= LOW_LVL) state_nxt = SEND_XON;
        else if (timer == 32'd0)              state_nxt = SEND_XOFF;
      end
      SEND_XON:  if (ack_take) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_r       <= 1'b0;
      val_r       <= 16'd0;
      xoff_active <= 1'b0;
      xoff_count  <= 16'd0;
      timer       <= 32'd0;
    end else begin
      state <= state_nxt;
      req_r <= (state_nxt == SEND_XOFF) || (state_nxt == SEND_XON);
      // val only moves on request entry, so it is stable for the whole req window
      if (state_nxt == SEND_XOFF && state != SEND_XOFF) val_r <= PAUSE_QUANTA;
      if (state_nxt == SEND_XON  && state != SEND_XON)  val_r <= 16'd0;
      case (state)
        SEND_XOFF: if (ack_take) begin
          xoff_active <= 1'b1;
          xoff_count  <= xoff_count + 16'd1;
          timer       <= R_LOAD;
        end
        PAUSED:    if (timer != 32'd0) timer <= timer - 32'd1;
        SEND_XON:  if (ack_take) begin
          xoff_active <= 1'b0;
          timer       <= 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
